// File: rtl/display_scan_controller.sv
// Multiplexed seven-segment scan sequencer: prescaled refresh tick, blanking gap,
// per-digit segment fetch over req/ack, then hold the digit lit until the next tick.
module display_scan_controller #(
  parameter int PRESCALE     = 250000,
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic                  cmosClock,
  input  logic                  reset,
  input  logic                  displayEnable,
  output logic                  digitReq,
  output logic [2:0]            digitIndex,
  input  logic                  digitAck,
  input  logic [7:0]            segmentIn,
  output logic [NUM_DIGITS-1:0] anodeOut,
  output logic [7:0]            segmentOut,
  output logic                  timeoutFlag,
  output logic                  overrunFlag
);

  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CMAX = (BLANK_CYCLES > ACK_TIMEOUT) ? BLANK_CYCLES : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, BLANK, FETCH, SHOW} state_t;

  state_t                r_state, w_state_nx;
  logic [PW-1:0]         r_presc;
  logic                  w_tick;
  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic [2:0]            r_idx, w_idx_nx, w_idx_inc;
  logic [7:0]            r_seg, w_seg_nx;
  logic                  r_pend, w_pend_nx;
  logic                  r_to, w_to_nx;
  logic                  r_ovr, w_ovr_nx;
  logic                  w_done;
  logic [NUM_DIGITS-1:0] w_onehot;

  assign w_tick    = (r_presc == PW'(PRESCALE - 1));
  assign w_idx_inc = (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;

  always_ff @(posedge cmosClock) begin
    if (reset)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  always_ff @(posedge cmosClock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'(NUM_DIGITS - 1);
      r_seg   <= 8'hFF;
      r_pend  <= 1'b0;
      r_to    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_seg   <= w_seg_nx;
      r_pend  <= w_pend_nx;
      r_to    <= w_to_nx;
      r_ovr   <= w_ovr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_seg_nx   = r_seg;
    w_pend_nx  = r_pend;
    w_to_nx    = 1'b0;
    w_ovr_nx   = r_ovr;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick && displayEnable) begin
          w_state_nx = BLANK;
          w_idx_nx   = w_idx_inc;
          w_cnt_nx   = CW'(BLANK_CYCLES - 1);
        end
      end
      BLANK, FETCH: begin
        // A tick that cannot be serviced now is remembered; a second one is lost.
        if (w_tick) begin
          w_pend_nx = 1'b1;
          if (r_pend) w_ovr_nx = 1'b1;
        end
        if (r_state == BLANK) begin
          if (r_cnt == '0) begin
            w_state_nx = FETCH;
            w_cnt_nx   = CW'(ACK_TIMEOUT - 1);
          end else begin
            w_cnt_nx = r_cnt - CW'(1);
          end
        end else begin
          if (digitAck) begin
            w_seg_nx = segmentIn;
            w_done   = 1'b1;
          end else if (r_cnt == '0) begin
            w_seg_nx = 8'hFF;
            w_to_nx  = 1'b1;
            w_done   = 1'b1;
          end else begin
            w_cnt_nx = r_cnt - CW'(1);
          end
          if (w_done) begin
            if (displayEnable) begin
              w_state_nx = SHOW;
            end else begin
              w_state_nx = IDLE;
              w_pend_nx  = 1'b0;
            end
          end
        end
      end
      SHOW: begin
        if (!displayEnable) begin
          w_state_nx = IDLE;
          w_pend_nx  = 1'b0;
        end else if (w_tick || r_pend) begin
          w_pend_nx  = 1'b0;
          w_idx_nx   = w_idx_inc;
          w_state_nx = BLANK;
          w_cnt_nx   = CW'(BLANK_CYCLES - 1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Enable gates the anodes after the register so blanking is immediate.
  assign w_onehot    = NUM_DIGITS'(1) << r_idx;
  assign anodeOut    = (r_state == SHOW && displayEnable) ? ~w_onehot : '1;
  assign digitReq    = (r_state == FETCH);
  assign digitIndex  = r_idx;
  assign segmentOut  = r_seg;
  assign timeoutFlag = r_to;
  assign overrunFlag = r_ovr;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: two instances (refresh periods 10 and 5) checked
// cycle by cycle against a phase/deadline model, plus directed scenario checks.
module tb_display_scan_controller;

  localparam int ND  = 4;
  localparam int BLK = 2;
  localparam int TMO = 4;
  localparam int M_IDLE = 0, M_BLANK = 1, M_FETCH = 2, M_SHOW = 3;

  typedef struct {
    int ph, idx, seg, pend, ovr, to, left, age, cyc;
  } mdl_t;

  logic       clk;
  logic       rst0, en0, ack0, rst1, en1, ack1;
  logic [7:0] sin0, sin1;
  logic       req0, to0, ov0, req1, to1, ov1;
  logic [2:0] idx0, idx1;
  logic [3:0] an0, an1;
  logic [7:0] so0, so1;
  logic [17:0] v0, v1;

  int total, bad;
  int rc0, dly0, sfix0, rc1, dly1;
  bit rnd0, spur0;
  mdl_t m0, m1;

  display_scan_controller #(.PRESCALE(10), .NUM_DIGITS(ND), .BLANK_CYCLES(BLK), .ACK_TIMEOUT(TMO)) u0 (
    .cmosClock(clk), .reset(rst0), .displayEnable(en0), .digitReq(req0), .digitIndex(idx0),
    .digitAck(ack0), .segmentIn(sin0), .anodeOut(an0), .segmentOut(so0),
    .timeoutFlag(to0), .overrunFlag(ov0));

  display_scan_controller #(.PRESCALE(5), .NUM_DIGITS(ND), .BLANK_CYCLES(BLK), .ACK_TIMEOUT(TMO)) u1 (
    .cmosClock(clk), .reset(rst1), .displayEnable(en1), .digitReq(req1), .digitIndex(idx1),
    .digitAck(ack1), .segmentIn(sin1), .anodeOut(an1), .segmentOut(so1),
    .timeoutFlag(to1), .overrunFlag(ov1));

  assign v0 = {req0, idx0, an0, so0, to0, ov0};
  assign v1 = {req1, idx1, an1, so1, to1, ov1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: refresh ticks fall on every P-th cycle since reset; blanking and fetch
  // are tracked as a remaining-cycle count and an age in cycles.
  function automatic mdl_t step(input mdl_t m, input logic rst, input logic en,
                                input logic ack, input logic [7:0] sin, input int P);
    mdl_t n;
    bit tick, done;
    n = m;
    done = 0;
    if (rst) begin
      n.ph = M_IDLE; n.idx = ND - 1; n.seg = 255; n.pend = 0; n.ovr = 0;
      n.to = 0; n.left = 0; n.age = 0; n.cyc = 0;
      return n;
    end
    tick  = (m.cyc % P) == P - 1;
    n.cyc = m.cyc + 1;
    n.to  = 0;
    case (m.ph)
      M_IDLE:
        if (tick && en) begin n.ph = M_BLANK; n.idx = (m.idx + 1) % ND; n.left = BLK; end
      M_BLANK, M_FETCH: begin
        if (tick) begin
          if (m.pend != 0) n.ovr = 1;
          n.pend = 1;
        end
        if (m.ph == M_BLANK) begin
          n.left = m.left - 1;
          if (n.left == 0) begin n.ph = M_FETCH; n.age = 0; end
        end else begin
          n.age = m.age + 1;
          if (ack) begin n.seg = sin; done = 1; end
          else if (n.age == TMO) begin n.seg = 255; n.to = 1; done = 1; end
          if (done) begin
            if (en) n.ph = M_SHOW;
            else begin n.ph = M_IDLE; n.pend = 0; end
          end
        end
      end
      default:
        if (!en) begin n.ph = M_IDLE; n.pend = 0; end
        else if (tick || m.pend != 0) begin
          n.pend = 0; n.idx = (m.idx + 1) % ND; n.ph = M_BLANK; n.left = BLK;
        end
    endcase
    return n;
  endfunction

  function automatic logic [17:0] expv(input mdl_t m, input logic en);
    logic [3:0] an;
    an = 4'hF;
    if (m.ph == M_SHOW && en) an[m.idx] = 1'b0;
    return {m.ph == M_FETCH, 3'(m.idx), an, 8'(m.seg), m.to[0], m.ovr[0]};
  endfunction

  always @(posedge clk) begin
    m0 <= step(m0, rst0, en0, ack0, sin0, 10);
    m1 <= step(m1, rst1, en1, ack1, sin1, 5);
  end

  // Segment source for instance 0: acks on the (dly0+1)-th request cycle.
  task automatic drv0();
    if (m0.ph == M_FETCH) rc0++; else rc0 = 0;
    if (rnd0 && rc0 == 1) dly0 = $urandom_range(0, 4);
    ack0 = (m0.ph == M_FETCH) ? (dly0 >= 0 && rc0 == dly0 + 1) : (spur0 && $urandom_range(0, 3) == 0);
    sin0 = (sfix0 >= 0) ? 8'(sfix0) : 8'($urandom);
  endtask

  task automatic drv1();
    if (m1.ph == M_FETCH) rc1++; else rc1 = 0;
    ack1 = (m1.ph == M_FETCH && rc1 == dly1 + 1);
    sin1 = 8'($urandom);
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst0 = 1'b0; drv0();
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] rv;
    rv = {1'b0, 3'd3, 4'hF, 8'hFF, 1'b0, 1'b0};
    rst0 = 1'b1; en0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 drv0(); #1;
      total++;
      if (v0 !== rv) begin bad++; $display("FAIL reset_state cyc%0d got=%h want=%h", k, v0, rv); end
    end
  endtask

  task automatic test_first_scan();
    int q[$];
    logic [3:0] prev;
    int want[5] = '{0, 1, 2, 3, 0};
    dly0 = 1; sfix0 = 8'hC0; rnd0 = 0; spur0 = 0; en0 = 1'b1;
    reset0();
    prev = 4'hF;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1 drv0(); #1;
      total++;
      if (v0 !== expv(m0, en0)) begin bad++; $display("FAIL first_scan_model cyc%0d got=%h want=%h", k, v0, expv(m0, en0)); end
      if (k == 9) begin
        total++;
        if (an0 !== 4'hF || so0 !== 8'hFF) begin bad++; $display("FAIL pre_tick_dark an=%h seg=%h want F/FF", an0, so0); end
      end
      if (k == 12) begin
        total++;
        if (req0 !== 1'b1 || idx0 !== 3'd0) begin bad++; $display("FAIL first_req req=%b idx=%0d want 1/0", req0, idx0); end
      end
      if (k == 14) begin
        total++;
        if (an0 !== 4'b1110 || so0 !== 8'hC0) begin bad++; $display("FAIL first_show an=%b seg=%h want 1110/C0", an0, so0); end
      end
      if (prev === 4'hF && an0 !== 4'hF) q.push_back(int'(idx0));
      prev = an0;
    end
    total++;
    if (q.size() < 5) begin bad++; $display("FAIL scan_order count got=%0d want>=5", q.size()); end
    else for (int i = 0; i < 5; i++) begin
      total++;
      if (q[i] != want[i]) begin bad++; $display("FAIL scan_order pos%0d got=%0d want=%0d", i, q[i], want[i]); end
    end
  endtask

  task automatic test_timeout();
    int pulses;
    dly0 = -1; sfix0 = -1; rnd0 = 0; spur0 = 0; en0 = 1'b1;
    reset0();
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1 drv0(); #1;
      total++;
      if (v0 !== expv(m0, en0)) begin bad++; $display("FAIL timeout_model cyc%0d got=%h want=%h", k, v0, expv(m0, en0)); end
      if (k <= 20 && to0 === 1'b1) pulses++;
      if (k == 16) begin
        total++;
        if (to0 !== 1'b1 || so0 !== 8'hFF || an0 !== 4'b1110)
          begin bad++; $display("FAIL timeout_show to=%b seg=%h an=%b want 1/FF/1110", to0, so0, an0); end
      end
      if (k == 17) begin
        total++;
        if (to0 !== 1'b0) begin bad++; $display("FAIL timeout_pulse_width to=%b want 0", to0); end
      end
      if (k == 26) begin
        total++;
        if (an0 !== 4'b1101) begin bad++; $display("FAIL timeout_next_digit an=%b want 1101", an0); end
      end
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL timeout_count got=%0d want=1", pulses); end
  endtask

  task automatic test_disable();
    int state, idle_k;
    dly0 = 1; sfix0 = -1; rnd0 = 0; spur0 = 0; en0 = 1'b1;
    reset0();
    state = 0; idle_k = 0;
    for (int k = 1; k <= 200 && state < 3; k++) begin
      @(posedge clk); #1 drv0();
      if (state == 1 && k == idle_k + 7) begin en0 = 1'b1; state = 2; end
      #1;
      total++;
      if (v0 !== expv(m0, en0)) begin bad++; $display("FAIL disable_model cyc%0d got=%h want=%h", k, v0, expv(m0, en0)); end
      if (state == 1 && k == idle_k + 1) begin
        total++;
        if (req0 !== 1'b0 || an0 !== 4'hF || idx0 !== 3'd2)
          begin bad++; $display("FAIL disable_idle req=%b an=%h idx=%0d want 0/F/2", req0, an0, idx0); end
      end
      if (state == 0 && an0 === 4'b1011) begin
        en0 = 1'b0;
        #1;
        total++;
        if (an0 !== 4'hF) begin bad++; $display("FAIL disable_mask an=%h want F", an0); end
        state = 1; idle_k = k;
      end else if (state == 2 && req0 === 1'b1) begin
        total++;
        if (idx0 !== 3'd3) begin bad++; $display("FAIL resume_index got=%0d want=3", idx0); end
        state = 3;
      end
    end
    total++;
    if (state != 3) begin bad++; $display("FAIL disable_scenario_bound stage=%0d want=3", state); end
  endtask

  task automatic test_reset_mid();
    int stage;
    dly0 = -1; sfix0 = -1; rnd0 = 0; spur0 = 0; en0 = 1'b1;
    reset0();
    stage = 0;
    for (int k = 1; k <= 80 && stage < 3; k++) begin
      @(posedge clk); #1 drv0(); #1;
      total++;
      if (v0 !== expv(m0, en0)) begin bad++; $display("FAIL rstmid_model cyc%0d got=%h want=%h", k, v0, expv(m0, en0)); end
      if (stage == 1) begin
        total++;
        if (req0 !== 1'b0 || an0 !== 4'hF || idx0 !== 3'd3)
          begin bad++; $display("FAIL rstmid_abort req=%b an=%h idx=%0d want 0/F/3", req0, an0, idx0); end
        rst0 = 1'b0; stage = 2;
      end else if (stage == 0 && req0 === 1'b1) begin
        rst0 = 1'b1; stage = 1;
      end else if (stage == 2 && req0 === 1'b1) begin
        total++;
        if (idx0 !== 3'd0) begin bad++; $display("FAIL rstmid_first_fetch idx=%0d want=0", idx0); end
        stage = 3;
      end
    end
    total++;
    if (stage != 3) begin bad++; $display("FAIL rstmid_bound stage=%0d want=3", stage); end
  endtask

  task automatic test_random();
    dly0 = 1; sfix0 = -1; rnd0 = 1; spur0 = 1; en0 = 1'b1;
    reset0();
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk); #1 drv0();
      if ($urandom_range(0, 59) == 0) en0 = ~en0;
      #1;
      total++;
      if (v0 !== expv(m0, en0)) begin bad++; $display("FAIL random_model cyc%0d got=%h want=%h", k, v0, expv(m0, en0)); end
    end
    rnd0 = 0; spur0 = 0; en0 = 1'b1;
  endtask

  task automatic test_overrun();
    int run, minrun;
    bit seen;
    rst1 = 1'b1; en1 = 1'b1; dly1 = 3;
    @(posedge clk);
    @(posedge clk);
    #1 rst1 = 1'b0; drv1();
    #1;
    run = 0; minrun = 1000; seen = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1 drv1(); #1;
      total++;
      if (v1 !== expv(m1, en1)) begin bad++; $display("FAIL overrun_model cyc%0d got=%h want=%h", k, v1, expv(m1, en1)); end
      if (an1 !== 4'hF) run++;
      else if (run > 0) begin if (run < minrun) minrun = run; run = 0; end
      if (seen) begin
        total++;
        if (ov1 !== 1'b1) begin bad++; $display("FAIL overrun_sticky cyc%0d got=%b want=1", k, ov1); end
      end
      if (ov1 === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL overrun_set got=0 want=1"); end
    total++;
    if (minrun != 1) begin bad++; $display("FAIL pending_show_len got=%0d want=1", minrun); end
    rst1 = 1'b1;
    @(posedge clk); #2;
    total++;
    if (ov1 !== 1'b0) begin bad++; $display("FAIL overrun_reset_clear got=%b want=0", ov1); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst0 = 1'b1; en0 = 1'b0; ack0 = 1'b0; sin0 = 8'h00;
    rst1 = 1'b1; en1 = 1'b0; ack1 = 1'b0; sin1 = 8'h00;
    rc0 = 0; dly0 = 1; sfix0 = -1; rnd0 = 0; spur0 = 0; rc1 = 0; dly1 = 3;
    test_reset();
    test_first_scan();
    test_timeout();
    test_disable();
    test_reset_mid();
    test_random();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
